// File: rtl/tm1638_seg_writer.sv
// TM1638 write-only display refresher: mode command, 16-byte data burst, display-control command.
// Optional feature macro TM1638_AUTO_REFRESH_EN: periodic self-start every REFRESH_CYCLES idle clocks.
module tm1638_seg_writer #(
    parameter int unsigned CLK_DIV        = 50,
    parameter int unsigned REFRESH_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] seg_data,
    input  logic [7:0]  leds,
    input  logic [2:0]  bright,
    input  logic        disp_on,
    output logic        tm_stb,
    output logic        tm_clk,
    output logic        tm_dio,
    output logic        busy,
    output logic        done
);

    if (CLK_DIV < 2) begin : g_bad_clk_div
        $error("CLK_DIV must be 2 or greater");
    end
    if (REFRESH_CYCLES < 1) begin : g_bad_refresh_cycles
        $error("REFRESH_CYCLES must be at least 1");
    end

    localparam int unsigned     HC_W    = $clog2(CLK_DIV);
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STB_LO,
        S_SHIFT,
        S_STB_HI,
        S_GAP,
        S_FIN
    } state_t;

    typedef enum logic [1:0] {
        FR_MODE,
        FR_DATA,
        FR_CTRL
    } frame_t;

    state_t          state_q, state_d;
    frame_t          frame_q, frame_d;
    logic [HC_W-1:0] hcnt_q, hcnt_d;
    logic            phase_q, phase_d;   // second half of a bit, or of the inter-frame gap
    logic [2:0]      bit_q, bit_d;
    logic [4:0]      byte_q, byte_d;
    logic            stb_d, clk_d, dio_d, busy_d, done_d;
    logic            half_end;
    logic [4:0]      byte_last;
    logic [7:0]      tx_byte;
    logic            go;

    logic [63:0]     seg_q;
    logic [7:0]      leds_q;
    logic [2:0]      bright_q;
    logic            disp_on_q;

    assign half_end  = (hcnt_q == HC_LAST);
    assign byte_last = (frame_q == FR_DATA) ? 5'd16 : 5'd0;

    // Data-frame index 0 is the address command; index k>0 maps to display address k-1.
    function automatic logic [7:0] frame_byte(input frame_t fr, input logic [4:0] idx);
        logic [3:0] addr;
        addr       = 4'(idx - 5'd1);
        frame_byte = 8'h00;
        case (fr)
            FR_MODE: frame_byte = 8'h40;
            FR_DATA: begin
                if (idx == 5'd0)
                    frame_byte = 8'hC0;
                else if (!addr[0])
                    frame_byte = seg_q[{addr[3:1], 3'b000} +: 8];
                else
                    frame_byte = {7'b0, leds_q[addr[3:1]]};
            end
            FR_CTRL: frame_byte = {4'b1000, disp_on_q, bright_q};
            default: frame_byte = 8'h00;
        endcase
    endfunction

`ifdef TM1638_AUTO_REFRESH_EN
    localparam int unsigned RC_W = $clog2(REFRESH_CYCLES + 1);

    logic [RC_W-1:0] rcnt_q;
    logic            auto_go;

    assign auto_go = (state_q == S_IDLE) && (rcnt_q == RC_W'(REFRESH_CYCLES - 1));
    assign go      = (state_q == S_IDLE) && (start || auto_go);

    // Counting starts in FIN so the next refresh lands REFRESH_CYCLES after done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rcnt_q <= '0;
        else if ((state_q == S_IDLE && !go) || state_q == S_FIN)
            rcnt_q <= rcnt_q + 1'b1;
        else
            rcnt_q <= '0;
    end
`else
    assign go = (state_q == S_IDLE) && start;
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d = state_q;
        frame_d = frame_q;
        hcnt_d  = half_end ? '0 : hcnt_q + 1'b1;
        phase_d = phase_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        stb_d   = tm_stb;
        clk_d   = tm_clk;
        dio_d   = tm_dio;
        tx_byte = 8'h00;

        unique case (state_q)
            S_IDLE: begin
                hcnt_d = '0;
                if (go) begin
                    state_d = S_STB_LO;
                    frame_d = FR_MODE;
                    stb_d   = 1'b0;
                    clk_d   = 1'b1;
                    dio_d   = 1'b1;
                end
            end

            S_STB_LO: begin
                if (half_end) begin
                    state_d = S_SHIFT;
                    tx_byte = frame_byte(frame_q, 5'd0);
                    clk_d   = 1'b0;
                    dio_d   = tx_byte[0];
                end
            end

            S_SHIFT: begin
                if (half_end) begin
                    if (!phase_q) begin
                        phase_d = 1'b1;
                        clk_d   = 1'b1;
                    end else if (bit_q == 3'd7 && byte_q == byte_last) begin
                        state_d = S_STB_HI;
                    end else begin
                        // DIO only moves on the falling CLK so it is settled at the rising edge.
                        phase_d = 1'b0;
                        clk_d   = 1'b0;
                        if (bit_q == 3'd7) begin
                            bit_d  = 3'd0;
                            byte_d = byte_q + 1'b1;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                        tx_byte = frame_byte(frame_q, byte_d);
                        dio_d   = tx_byte[bit_d];
                    end
                end
            end

            S_STB_HI: begin
                if (half_end) begin
                    state_d = S_GAP;
                    stb_d   = 1'b1;
                    clk_d   = 1'b1;
                    dio_d   = 1'b1;
                end
            end

            S_GAP: begin
                if (half_end) begin
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else if (frame_q == FR_CTRL) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_STB_LO;
                        frame_d = (frame_q == FR_MODE) ? FR_DATA : FR_CTRL;
                        stb_d   = 1'b0;
                    end
                end
            end

            S_FIN: begin
                hcnt_d  = '0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                stb_d   = 1'b1;
                clk_d   = 1'b1;
                dio_d   = 1'b1;
            end
        endcase

        if (state_d != state_q) begin
            hcnt_d  = '0;
            phase_d = 1'b0;
            bit_d   = '0;
            byte_d  = '0;
        end

        busy_d = (state_d != S_IDLE) && (state_d != S_FIN);
        done_d = (state_d == S_FIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            frame_q   <= FR_MODE;
            hcnt_q    <= '0;
            phase_q   <= 1'b0;
            bit_q     <= '0;
            byte_q    <= '0;
            tm_stb    <= 1'b1;
            tm_clk    <= 1'b1;
            tm_dio    <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            seg_q     <= '0;
            leds_q    <= '0;
            bright_q  <= '0;
            disp_on_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            frame_q <= frame_d;
            hcnt_q  <= hcnt_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            tm_stb  <= stb_d;
            tm_clk  <= clk_d;
            tm_dio  <= dio_d;
            busy    <= busy_d;
            done    <= done_d;
            if (go) begin
                seg_q     <= seg_data;
                leds_q    <= leds;
                bright_q  <= bright;
                disp_on_q <= disp_on;
            end
        end
    end

endmodule
